// File: rtl/organ_pkg.sv
`default_nettype none
// ============================================================================
// organ_pkg : shared modes, timebase rate and segment layout for the organ
// Rev 1.0
// ============================================================================
package organ_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2
    } mode_e;

    localparam int TICK_HZ   = 100;
    localparam int SEG_DUR_W = 8;

    typedef struct packed {
        logic                 rest;
        logic [3:0]           key;
        logic [SEG_DUR_W-1:0] dur;
    } seg_t;

endpackage
`default_nettype wire

// File: rtl/seg_ram.sv
`default_nettype none
// ============================================================================
// seg_ram : single-port synchronous segment buffer, read-before-write
// Rev 1.0
// ============================================================================
module seg_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 13,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/note_recorder.sv
`default_nettype none
// ============================================================================
// note_recorder : live / record / playback stage between keypad_scan and decode
// Build option: NOTE_RECORDER_LOOP_EN makes playback wrap until stopped. Rev 1.0
// ============================================================================
module note_recorder
    import organ_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DUR_W = SEG_DUR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [3:0]                 key,
    input  logic                       pressed,
    input  logic                       rec,
    input  logic                       play,
    output logic [3:0]                 key_out,
    output logic                       key_valid,
    output logic [1:0]                 mode,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = 5 + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX   = '1;
    localparam logic [CW-1:0]    LAST_SLOT = CW'(DEPTH - 1);
`ifdef NOTE_RECORDER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef struct packed {
        logic             rest;
        logic [3:0]       key;
        logic [DUR_W-1:0] dur;
    } rec_seg_t;

    mode_e            r_state;
    logic [3:0]       r_key_out;
    logic             r_key_valid;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_open;
    rec_seg_t         r_seg;
    rec_seg_t         r_first;
    logic [AW-1:0]    r_idx;
    logic [DUR_W-1:0] r_left;

    logic             w_play;
    logic             w_differs;
    logic             w_we;
    logic             w_is_last;
    logic             w_adv;
    logic [DUR_W-1:0] w_dur_inc;
    rec_seg_t         w_wseg;
    rec_seg_t         w_rseg;
    logic [AW-1:0]    w_next_idx;
    logic [AW-1:0]    w_after_next;
    logic [AW-1:0]    w_addr;
    logic [SW-1:0]    w_rdata;

    function automatic logic [AW-1:0] f_succ(input logic [AW-1:0] idx, input logic [CW-1:0] cnt);
        f_succ = ((CW'(idx) + CW'(1)) == cnt) ? '0 : idx + AW'(1);
    endfunction

    always_comb begin
        w_play       = play & ~rec;
        w_dur_inc    = r_seg.dur + DUR_W'(1);
        w_differs    = (pressed == r_seg.rest) || (pressed && (key != r_seg.key));
        w_is_last    = (CW'(r_idx) + CW'(1)) == r_count;
        w_next_idx   = f_succ(r_idx, r_count);
        w_after_next = f_succ(w_next_idx, r_count);
        w_adv        = (r_state == MODE_PLAY) && !w_play && tick && (r_left == DUR_W'(1));
        w_we         = 1'b0;
        w_wseg       = r_seg;
        if (r_state == MODE_REC) begin
            if (rec) begin
                w_we = r_open && (r_seg.dur != '0);
            end else if (tick && r_open) begin
                if (w_differs) begin
                    w_we = (r_seg.dur != '0);
                end else if (w_dur_inc == DUR_MAX) begin
                    w_we       = 1'b1;
                    w_wseg.dur = DUR_MAX;
                end
            end
        end
        // Address always points at the entry that follows the one on the outputs,
        // so the next segment is already in the read register at each boundary.
        case (r_state)
            MODE_REC:  w_addr = AW'(r_count);
            MODE_PLAY: w_addr = w_adv ? w_after_next : w_next_idx;
            default:   w_addr = (r_count == CW'(1)) ? '0 : AW'(1);
        endcase
    end

    assign w_rseg = w_rdata;

    seg_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SW),
        .AW    (AW)
    ) u_seg_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wseg),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= MODE_IDLE;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_open      <= 1'b0;
            r_seg       <= '0;
            r_first     <= '0;
            r_idx       <= '0;
            r_left      <= '0;
        end else begin
            case (r_state)
                MODE_IDLE: begin
                    r_key_out   <= key;
                    r_key_valid <= pressed;
                    if (rec) begin
                        r_state <= MODE_REC;
                        r_count <= '0;
                        r_full  <= 1'b0;
                        r_open  <= 1'b0;
                    end else if (play && (r_count != '0)) begin
                        r_state     <= MODE_PLAY;
                        r_idx       <= '0;
                        r_key_out   <= r_first.key;
                        r_key_valid <= ~r_first.rest;
                        r_left      <= r_first.dur;
                    end
                end
                MODE_REC: begin
                    r_key_out   <= key;
                    r_key_valid <= pressed;
                    if (w_we) begin
                        r_count <= r_count + CW'(1);
                        if (r_count == '0) begin
                            r_first <= w_wseg;
                        end
                        if (r_count == LAST_SLOT) begin
                            r_full  <= 1'b1;
                            r_state <= MODE_IDLE;
                        end
                    end
                    if (rec) begin
                        r_state <= MODE_IDLE;
                        r_open  <= 1'b0;
                    end else if (tick) begin
                        if (!r_open) begin
                            if (pressed) begin
                                r_open <= 1'b1;
                                r_seg  <= '{1'b0, key, DUR_W'(1)};
                            end
                        end else if (w_differs) begin
                            r_seg <= '{~pressed, key, DUR_W'(1)};
                        end else if (w_dur_inc == DUR_MAX) begin
                            r_seg.dur <= '0;
                        end else begin
                            r_seg.dur <= w_dur_inc;
                        end
                    end
                end
                MODE_PLAY: begin
                    if (w_play) begin
                        r_state     <= MODE_IDLE;
                        r_key_out   <= key;
                        r_key_valid <= 1'b0;
                    end else if (tick) begin
                        if (r_left == DUR_W'(1)) begin
                            if (w_is_last && !LOOP_EN) begin
                                r_state     <= MODE_IDLE;
                                r_key_out   <= key;
                                r_key_valid <= 1'b0;
                            end else begin
                                r_idx       <= w_next_idx;
                                r_key_out   <= w_rseg.key;
                                r_key_valid <= ~w_rseg.rest;
                                r_left      <= w_rseg.dur;
                            end
                        end else begin
                            r_left <= r_left - DUR_W'(1);
                        end
                    end
                end
                default: r_state <= MODE_IDLE;
            endcase
        end
    end

    assign key_out   = r_key_out;
    assign key_valid = r_key_valid;
    assign mode      = r_state;
    assign count     = r_count;
    assign full      = r_full;

endmodule
`default_nettype wire

// File: tb/tb_note_recorder.sv
`default_nettype none
// ============================================================================
// tb_note_recorder : directed stimulus against a segment-list model of the recorder
// Rev 1.0
// ============================================================================
module tb_note_recorder;

    localparam int DEPTH = 4;
    localparam int DUR_W = 8;
    localparam int DMAX  = (1 << DUR_W) - 1;
`ifdef NOTE_RECORDER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] key = 4'd0;
    logic       pressed = 1'b0;
    logic       rec = 1'b0;
    logic       play = 1'b0;
    logic [3:0] key_out;
    logic       key_valid;
    logic [1:0] mode;
    logic [2:0] count;
    logic       full;

    always #5 clk = ~clk;

    note_recorder #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .key       (key),
        .pressed   (pressed),
        .rec       (rec),
        .play      (play),
        .key_out   (key_out),
        .key_valid (key_valid),
        .mode      (mode),
        .count     (count),
        .full      (full)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the recording is a list of (rest,key,dur) runs; playback walks it by elapsed ticks.
    typedef struct {
        bit       rest;
        bit [3:0] key;
        int       dur;
    } mseg_t;

    mseg_t    m_seg[$];
    int       m_mode, m_odur, m_pi, m_pt;
    bit [3:0] m_kout, m_okey;
    bit       m_kv, m_full, m_open, m_orest;

    function automatic void m_push(input bit r, input bit [3:0] k, input int d);
        mseg_t s;
        s.rest = r; s.key = k; s.dur = d;
        m_seg.push_back(s);
        if (m_seg.size() == DEPTH) begin
            m_full = 1'b1;
            m_mode = 0;
        end
    endfunction

    task automatic model_step();
        bit rq, pq;
        rq = rec;
        pq = play && !rec;
        case (m_mode)
            0: begin
                m_kout = key; m_kv = pressed;
                if (rq) begin
                    m_mode = 1; m_seg.delete(); m_full = 1'b0; m_open = 1'b0;
                end else if (pq && m_seg.size() > 0) begin
                    m_mode = 2; m_pi = 0; m_pt = 0;
                    m_kout = m_seg[0].key; m_kv = !m_seg[0].rest;
                end
            end
            1: begin
                m_kout = key; m_kv = pressed;
                if (rq) begin
                    if (m_open && m_odur > 0) m_push(m_orest, m_okey, m_odur);
                    m_mode = 0;
                end else if (tick) begin
                    if (!m_open) begin
                        if (pressed) begin
                            m_open = 1'b1; m_orest = 1'b0; m_okey = key; m_odur = 1;
                        end
                    end else if ((pressed == m_orest) || (pressed && key != m_okey)) begin
                        if (m_odur > 0) m_push(m_orest, m_okey, m_odur);
                        m_orest = !pressed; m_okey = key; m_odur = 1;
                    end else begin
                        m_odur++;
                        if (m_odur == DMAX) begin
                            m_push(m_orest, m_okey, DMAX);
                            m_odur = 0;
                        end
                    end
                end
            end
            default: begin
                if (pq) begin
                    m_mode = 0; m_kout = key; m_kv = 1'b0;
                end else if (tick) begin
                    m_pt++;
                    if (m_pt == m_seg[m_pi].dur) begin
                        m_pt = 0;
                        m_pi++;
                        if (m_pi == m_seg.size()) begin
                            if (LOOP) m_pi = 0;
                            else begin
                                m_mode = 0; m_kout = key; m_kv = 1'b0;
                            end
                        end
                        if (m_mode == 2) begin
                            m_kout = m_seg[m_pi].key; m_kv = !m_seg[m_pi].rest;
                        end
                    end
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_kout = 4'd0; m_kv = 1'b0; m_full = 1'b0;
            m_open = 1'b0; m_pi = 0; m_pt = 0; m_odur = 0;
            m_seg.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mode", mode, m_mode);
            check("key_valid", key_valid, m_kv);
            check("count", count, m_seg.size());
            check("full", full, m_full);
            if (m_mode != 2 || m_kv) check("key_out", key_out, m_kout);
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic pulse_rec();
        rec = 1'b1;
        @(negedge clk);
        rec = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_key_out", key_out, 0);
        check("reset_valid", key_valid, 0);
        check("reset_mode", mode, 0);
        check("reset_count", count, 0);
        check("reset_full", full, 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        key = 4'd5; pressed = 1'b1;
        @(negedge clk);
        check("live_key", key_out, 5);
        check("live_valid", key_valid, 1);
        check("live_mode", mode, 0);
        pressed = 1'b0;
        @(negedge clk);

        pulse_play();
        check("empty_play_mode", mode, 0);

        rec = 1'b1; play = 1'b1;
        @(negedge clk);
        rec = 1'b0; play = 1'b0;
        check("recplay_mode", mode, 1);
        pulse_rec();
        check("empty_rec_count", count, 0);

        pulse_rec();
        key = 4'd3; pressed = 1'b1; ticks(10);
        pressed = 1'b0;             ticks(4);
        key = 4'd7; pressed = 1'b1; ticks(6);
        pressed = 1'b0;
        pulse_rec();
        @(negedge clk);
        check("rec_count", count, 3);
        check("model_n", m_seg.size(), 3);
        check("model_e0", {m_seg[0].rest, m_seg[0].key, m_seg[0].dur[7:0]}, {1'b0, 4'd3, 8'd10});
        check("model_e1", {m_seg[1].rest, m_seg[1].dur[7:0]}, {1'b1, 8'd4});
        check("model_e2", {m_seg[2].rest, m_seg[2].key, m_seg[2].dur[7:0]}, {1'b0, 4'd7, 8'd6});

        pulse_play();
        check("pb_first_key", key_out, 3);
        check("pb_first_valid", key_valid, 1);
        check("pb_mode", mode, 2);
        ticks(9);
        check("pb_hold_valid", key_valid, 1);
        ticks(1);
        check("pb_rest_valid", key_valid, 0);
        ticks(4);
        check("pb_second_key", key_out, 7);
        check("pb_second_valid", key_valid, 1);
        ticks(6);
`ifdef NOTE_RECORDER_LOOP_EN
        check("pb_wrap_mode", mode, 2);
        check("pb_wrap_key", key_out, 3);
        check("pb_wrap_valid", key_valid, 1);
        pulse_play();
        check("pb_stop_mode", mode, 0);
        check("pb_stop_valid", key_valid, 0);
`else
        check("pb_end_mode", mode, 0);
        check("pb_end_valid", key_valid, 0);
`endif

        pulse_rec();
        key = 4'd1; pressed = 1'b1; ticks(600);
        check("sat_count", count, 2);
        check("model_sat0", m_seg[0].dur, 255);
        check("model_sat1", m_seg[1].dur, 255);
        pressed = 1'b0;             ticks(2);
        key = 4'd2; pressed = 1'b1; ticks(1);
        check("full_flag", full, 1);
        check("full_mode", mode, 0);
        check("full_count", count, 4);
        check("model_sat2", m_seg[2].dur, 90);
        check("model_sat3", {m_seg[3].rest, m_seg[3].dur[7:0]}, {1'b1, 8'd2});

        pressed = 1'b0;
        pulse_play();
        check("rst_pb_mode", mode, 2);
        check("rst_pb_key", key_out, 1);
        ticks(5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_key_out", key_out, 0);
        check("rst_mid_valid", key_valid, 0);
        check("rst_mid_mode", mode, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_play();
        check("post_rst_play_mode", mode, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
